a_execute: RTL and testbench
============================

Name: a_execute

Overview:
Execute stage, directly downstream of decode. It accepts one decoded instruction per handshake and computes the ALU result or load/store address. It resolves beq/bne and drives a one-cycle fetch redirect, then registers the result with writeback/memory control for the memory stage. An iterative multiplier stalls decode while busy; a taken branch squashes the one wrong-path instruction behind it.

Parameters:
XLEN, 32, datapath width
MUL_CYCLES, 32, multiplier iterations; must equal XLEN

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
d_ready  in  1  decode holds a valid instruction (valid)
da_pc  in  32  instruction PC
da_data1  in  32  rs1 value
da_data2  in  32  rs2 value
da_imm32  in  32  sign-extended immediate
da_use_imm  in  1  operand B = da_imm32 (decode asserts for I-type/load/store)
da_ALU_Control  in  6  operation code
da_target_PC  in  32  branch target
da_is_branch, da_is_load, da_is_store, da_is_wb  in  1 each  class flags
da_write_sel  in  5  destination register
m_ready  in  1  memory stage can accept
a_ready  out  1  execute can accept (to decode)
a_branch_taken  out  1  one-cycle redirect pulse to fetch
a_target_pc  out  32  redirect PC
am_valid  out  1  result registers valid
am_alu_result  out  32  ALU result / memory address
am_store_data  out  32  da_data2 passthrough
am_write_sel  out  5  destination register
am_is_wb, am_is_load, am_is_store  out  1 each  control passthrough

Behaviour:
- Reset (async, reset==0): all outputs 0, state RUN, counter 0.
- Operand A = da_data1; operand B = da_use_imm ? da_imm32 : da_data2.
- ALU_Control codes:
  - 000000 add; 000001 sub; 000010 and; 000011 or; 000100 xor
  - 000101 sll, 000110 srl, 000111 sra (shift amount = B[4:0])
  - 001000 slt (signed); 001001 sltu
  - 010000 beq; 010001 bne
  - 100000 mul (low 32 bits)
  - any other code gives result 0.
- Accept: a transfer occurs on the rising edge where d_ready && a_ready.
- a_ready = (state==RUN || state==FLUSH) && (!am_valid || m_ready). This is combinational.
- Single-cycle op accepted at edge N: am_* are registered at edge N, so am_valid=1 during cycle N+1.
- Backpressure: while am_valid && !m_ready, all am_* hold unchanged.
- If am_valid && m_ready and nothing is accepted, am_valid clears at that edge.
- Branch (da_is_branch): taken if beq && A==B, or bne && A!=B.
  - Taken at accept edge N: a_branch_taken=1 and a_target_pc=da_target_PC for exactly cycle N+1, then a_branch_taken returns to 0.
  - Branch produces am_valid=1 with am_is_wb=0, am_is_load=0, am_is_store=0.
  - After a taken branch, state becomes FLUSH.
- FLUSH: the next accepted instruction is discarded (am_valid stays 0, no redirect even if it is a branch), then state returns to RUN. A not-taken branch does not enter FLUSH.
- MUL_BUSY: a mul accepted at edge N loads the operands and counter=31, and enters MUL_BUSY.
  - Each edge does one shift-add step; a_ready=0 throughout.
  - At the edge where counter==0, the product is registered, am_valid=1 and state returns to RUN. am_valid therefore rises at edge N+32.
  - Result is the low XLEN bits; signed and unsigned low halves are identical.
  - MUL_BUSY is entered only when am_valid==0 or m_ready==1, so no result is lost.
- Reset mid-multiply: aborts immediately to the reset values.
- Reset during FLUSH: clears it; no instruction is squashed.
- Arithmetic wraps modulo 2^32; no overflow flags.

Optional Feature:
- Macro A_EXECUTE_MUL_EN.
- Defined: mul (100000) uses the iterative multiplier and the MUL_BUSY state exists.
- Undefined: no multiplier or counter is synthesised; 100000 completes in one cycle with am_alu_result=0, and the state machine has only RUN and FLUSH.

Decomposition:
- Shared package core_defines.v holds:
  - ALU_Control code constants
  - state encodings RUN=2'd0, MUL_BUSY=2'd1, FLUSH=2'd2
  - XLEN
- One sub-module: a_mul_iter, the shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done pulse, product.
- ALU and branch-compare logic stay combinational inside a_execute.

Test Plan:
- Add: data1=5, data2=7, ctrl 000000, use_imm=0, m_ready=1 -> next cycle am_valid=1, am_alu_result=12.
- Load: data1=0x100, imm32=0xFFFFFFFC, use_imm=1, is_load=1 -> am_alu_result=0xFC, am_is_load=1, am_is_wb=1.
- Backpressure: m_ready=0 with am_valid=1 -> a_ready=0 and am_* stable for 3 cycles; after m_ready=1 the next instruction is accepted.
- Branch taken, then squash:
  - beq with data1=data2=9, target_PC=0x40 -> a_branch_taken=1 for one cycle with a_target_pc=0x40.
  - The following addi is accepted with am_valid=0.
  - The instruction after it executes normally.
- Branch not taken: bne with data1=data2=3 -> a_branch_taken stays 0 and the next instruction is not squashed.
- Multiply (A_EXECUTE_MUL_EN): 0xFFFFFFFF*3 accepted at edge N -> a_ready=0 until am_valid=1 at edge N+32, result 0xFFFFFFFD. Asserting reset at cycle N+10 gives all outputs 0 and a_ready=1.

Source files
------------

// File: rtl/a_execute_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes, FSM states.
package a_execute_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] AluAdd  = 6'b000000;
  localparam logic [5:0] AluSub  = 6'b000001;
  localparam logic [5:0] AluAnd  = 6'b000010;
  localparam logic [5:0] AluOr   = 6'b000011;
  localparam logic [5:0] AluXor  = 6'b000100;
  localparam logic [5:0] AluSll  = 6'b000101;
  localparam logic [5:0] AluSrl  = 6'b000110;
  localparam logic [5:0] AluSra  = 6'b000111;
  localparam logic [5:0] AluSlt  = 6'b001000;
  localparam logic [5:0] AluSltu = 6'b001001;
  localparam logic [5:0] AluBeq  = 6'b010000;
  localparam logic [5:0] AluBne  = 6'b010001;
  localparam logic [5:0] AluMul  = 6'b100000;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMulBusy = 2'd1,
    StFlush   = 2'd2
  } state_e;

endpackage

// File: rtl/a_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock; keeps the low XLEN bits.
// done/product are combinational in the last iteration so the caller registers on that edge.
module a_mul_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);

  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, step_acc;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  always_comb begin
    step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == '0);
    product  = step_acc;
    busy     = busy_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= CntW'(MUL_CYCLES - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= step_acc;
      mcand_q  <= {mcand_q[XLEN-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
      cnt_q    <= cnt_q - CntW'(1);
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/a_execute.sv
// Execute stage: ALU, beq/bne resolution with one-slot squash, result register to memory.
// Define A_EXECUTE_MUL_EN to build the iterative multiplier for op 100000.
module a_execute
  import a_execute_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            d_ready,
  input  logic [XLEN-1:0] da_pc,
  input  logic [XLEN-1:0] da_data1,
  input  logic [XLEN-1:0] da_data2,
  input  logic [XLEN-1:0] da_imm32,
  input  logic            da_use_imm,
  input  logic [5:0]      da_ALU_Control,
  input  logic [XLEN-1:0] da_target_PC,
  input  logic            da_is_branch,
  input  logic            da_is_load,
  input  logic            da_is_store,
  input  logic            da_is_wb,
  input  logic [4:0]      da_write_sel,
  input  logic            m_ready,
  output logic            a_ready,
  output logic            a_branch_taken,
  output logic [XLEN-1:0] a_target_pc,
  output logic            am_valid,
  output logic [XLEN-1:0] am_alu_result,
  output logic [XLEN-1:0] am_store_data,
  output logic [4:0]      am_write_sel,
  output logic            am_is_wb,
  output logic            am_is_load,
  output logic            am_is_store
);

  localparam int unsigned ShW = $clog2(XLEN);

  if (MUL_CYCLES != XLEN) begin : g_cfg_err
    $error("a_execute: MUL_CYCLES must equal XLEN");
  end

  state_e          state_q, state_d;
  logic            valid_q, valid_d, taken_q, taken_d;
  logic [XLEN-1:0] result_q, result_d, sdata_q, sdata_d, target_q, target_d;
  logic [4:0]      wsel_q, wsel_d;
  logic            wb_q, wb_d, ld_q, ld_d, st_q, st_d;

  logic [XLEN-1:0] op_a, op_b, alu_out;
  logic            br_taken, accept, is_mul, mul_idle;

  // da_pc is carried by decode for tracing; the redirect uses the precomputed target.
  logic unused_pc;
  assign unused_pc = ^da_pc;

`ifdef A_EXECUTE_MUL_EN
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  assign is_mul    = (da_ALU_Control == AluMul);
  assign mul_start = accept && (state_q == StRun) && is_mul;
  assign mul_idle  = !mul_busy;

  a_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_idle = 1'b1;
`endif

  assign a_ready = ((state_q == StRun) || (state_q == StFlush)) && mul_idle &&
                   (!valid_q || m_ready);
  assign accept  = d_ready && a_ready;

  always_comb begin
    op_a    = da_data1;
    op_b    = da_use_imm ? da_imm32 : da_data2;
    alu_out = '0;
    case (da_ALU_Control)
      AluAdd:  alu_out = op_a + op_b;
      AluSub:  alu_out = op_a - op_b;
      AluAnd:  alu_out = op_a & op_b;
      AluOr:   alu_out = op_a | op_b;
      AluXor:  alu_out = op_a ^ op_b;
      AluSll:  alu_out = op_a << op_b[ShW-1:0];
      AluSrl:  alu_out = op_a >> op_b[ShW-1:0];
      AluSra:  alu_out = $unsigned($signed(op_a) >>> op_b[ShW-1:0]);
      AluSlt:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_out = '0;
    endcase
    br_taken = da_is_branch && (((da_ALU_Control == AluBeq) && (op_a == op_b)) ||
                                ((da_ALU_Control == AluBne) && (op_a != op_b)));
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    taken_d  = 1'b0;
    target_d = target_q;
    result_d = result_q;
    sdata_d  = sdata_q;
    wsel_d   = wsel_q;
    wb_d     = wb_q;
    ld_d     = ld_q;
    st_d     = st_q;

    unique case (state_q)
      StRun: begin
        if (accept) begin
          // Control fields are captured now; a multiply only fills in the result later.
          sdata_d  = da_data2;
          wsel_d   = da_write_sel;
          wb_d     = da_is_wb && !da_is_branch;
          ld_d     = da_is_load && !da_is_branch;
          st_d     = da_is_store && !da_is_branch;
          result_d = alu_out;
          if (is_mul) begin
            valid_d = 1'b0;
            state_d = StMulBusy;
          end else begin
            valid_d = 1'b1;
            if (br_taken) begin
              taken_d  = 1'b1;
              target_d = da_target_PC;
              state_d  = StFlush;
            end
          end
        end else if (valid_q && m_ready) begin
          valid_d = 1'b0;
        end
      end
      StFlush: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = StRun;
        end else if (valid_q && m_ready) begin
          valid_d = 1'b0;
        end
      end
`ifdef A_EXECUTE_MUL_EN
      StMulBusy: begin
        if (mul_done) begin
          result_d = mul_product;
          valid_d  = 1'b1;
          state_d  = StRun;
        end
      end
`endif
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      result_q <= '0;
      sdata_q  <= '0;
      wsel_q   <= '0;
      wb_q     <= 1'b0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      wsel_q   <= wsel_d;
      wb_q     <= wb_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
    end
  end

  assign a_branch_taken = taken_q;
  assign a_target_pc    = target_q;
  assign am_valid       = valid_q;
  assign am_alu_result  = result_q;
  assign am_store_data  = sdata_q;
  assign am_write_sel   = wsel_q;
  assign am_is_wb       = wb_q;
  assign am_is_load     = ld_q;
  assign am_is_store    = st_q;

endmodule

// File: tb/tb_a_execute.sv
// Self-checking bench for a_execute: vector table, directed corner sequences, random vs model.
module tb_a_execute;

`ifdef A_EXECUTE_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        d_ready = 1'b0, m_ready = 1'b1;
  logic [31:0] da_pc = '0, da_data1 = '0, da_data2 = '0, da_imm32 = '0, da_target_PC = '0;
  logic        da_use_imm = 1'b0, da_is_branch = 1'b0, da_is_load = 1'b0;
  logic        da_is_store = 1'b0, da_is_wb = 1'b0;
  logic [5:0]  da_ALU_Control = '0;
  logic [4:0]  da_write_sel = '0;
  logic        a_ready, a_branch_taken, am_valid, am_is_wb, am_is_load, am_is_store;
  logic [31:0] a_target_pc, am_alu_result, am_store_data;
  logic [4:0]  am_write_sel;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  a_execute dut (
    .clock(clock), .reset(reset), .d_ready(d_ready), .da_pc(da_pc), .da_data1(da_data1),
    .da_data2(da_data2), .da_imm32(da_imm32), .da_use_imm(da_use_imm),
    .da_ALU_Control(da_ALU_Control), .da_target_PC(da_target_PC), .da_is_branch(da_is_branch),
    .da_is_load(da_is_load), .da_is_store(da_is_store), .da_is_wb(da_is_wb),
    .da_write_sel(da_write_sel), .m_ready(m_ready), .a_ready(a_ready),
    .a_branch_taken(a_branch_taken), .a_target_pc(a_target_pc), .am_valid(am_valid),
    .am_alu_result(am_alu_result), .am_store_data(am_store_data), .am_write_sel(am_write_sel),
    .am_is_wb(am_is_wb), .am_is_load(am_is_load), .am_is_store(am_is_store)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [5:0] c, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui, input logic br,
                        input logic ld, input logic st, input logic wb, input logic [31:0] tpc);
    da_ALU_Control = c; da_data1 = d1; da_data2 = d2; da_imm32 = imm; da_use_imm = ui;
    da_is_branch = br; da_is_load = ld; da_is_store = st; da_is_wb = wb; da_target_PC = tpc;
    da_write_sel = 5'd3; d_ready = 1'b1;
  endtask

  // Reference ALU straight from the op table.
  function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c)
      6'd0:  return a + b;
      6'd1:  return a - b;
      6'd2:  return a & b;
      6'd3:  return a | b;
      6'd4:  return a ^ b;
      6'd5:  return a << sh;
      6'd6:  return a >> sh;
      6'd7:  return $unsigned($signed(a) >>> sh);
      6'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd9:  return (a < b) ? 32'd1 : 32'd0;
      6'd32: return MulEn ? a * b : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] d1, d2, imm;
    logic        ui, ld, wb;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[13];

  // Behavioural model state for the random phase.
  bit          m_valid, m_bt, m_flush, m_wb, m_ld, m_st;
  int          m_mul_left;
  logic [31:0] m_res, m_sd, m_tpc, m_prod;
  logic [4:0]  m_ws;

  logic [5:0] codes[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic exp_ready;
    logic [31:0] a, b;

    tbl[0]  = '{6'd0,  32'd5,        32'd7,        32'd0,        1'b0, 1'b0, 1'b1, 32'd12};
    tbl[1]  = '{6'd0,  32'h100,      32'd0,        32'hFFFFFFFC, 1'b1, 1'b1, 1'b1, 32'hFC};
    tbl[2]  = '{6'd1,  32'd3,        32'd5,        32'd0,        1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    tbl[3]  = '{6'd2,  32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b0, 1'b1, 32'hF000};
    tbl[4]  = '{6'd3,  32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b0, 1'b1, 32'hFFF0};
    tbl[5]  = '{6'd4,  32'hF0F0,     32'd0,        32'hFF00,     1'b1, 1'b0, 1'b1, 32'h0FF0};
    tbl[6]  = '{6'd5,  32'd1,        32'd31,       32'd0,        1'b0, 1'b0, 1'b1, 32'h80000000};
    tbl[7]  = '{6'd5,  32'd1,        32'd33,       32'd0,        1'b0, 1'b0, 1'b1, 32'd2};
    tbl[8]  = '{6'd6,  32'h80000000, 32'd4,        32'd0,        1'b0, 1'b0, 1'b1, 32'h08000000};
    tbl[9]  = '{6'd7,  32'h80000000, 32'd4,        32'd0,        1'b0, 1'b0, 1'b1, 32'hF8000000};
    tbl[10] = '{6'd8,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1'b1, 32'd1};
    tbl[11] = '{6'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1'b1, 32'd0};
    tbl[12] = '{6'd63, 32'd9,        32'd9,        32'd0,        1'b0, 1'b0, 1'b1, 32'd0};
    codes = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
              6'd16, 6'd17, 6'd32, 6'd63, 6'd10};

    // Reset values
    #12;
    chk("rst_valid", {31'd0, am_valid}, 32'd0);
    chk("rst_result", am_alu_result, 32'd0);
    chk("rst_taken", {31'd0, a_branch_taken}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_wsel", {27'd0, am_write_sel}, 32'd0);
    reset = 1'b1;
    tick();

    // Single-cycle op table
    foreach (tbl[i]) begin
      set_in(tbl[i].ctrl, tbl[i].d1, tbl[i].d2, tbl[i].imm, tbl[i].ui, 1'b0, tbl[i].ld, 1'b0,
             tbl[i].wb, 32'd0);
      tick();
      d_ready = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, am_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), am_alu_result, tbl[i].res);
      chk($sformatf("vec%0d_load", i), {31'd0, am_is_load}, {31'd0, tbl[i].ld});
      chk($sformatf("vec%0d_wb", i), {31'd0, am_is_wb}, {31'd0, tbl[i].wb});
      chk($sformatf("vec%0d_sdata", i), am_store_data, tbl[i].d2);
      tick();
      chk($sformatf("vec%0d_drain", i), {31'd0, am_valid}, 32'd0);
    end

    // Backpressure holds the result and blocks decode
    m_ready = 1'b0;
    set_in(6'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    set_in(6'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready", {31'd0, a_ready}, 32'd0);
      chk("bp_valid", {31'd0, am_valid}, 32'd1);
      chk("bp_hold", am_alu_result, 32'd3);
      tick();
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, a_ready}, 32'd1);
    tick();
    d_ready = 1'b0;
    chk("bp_next_result", am_alu_result, 32'd30);
    tick();

    // Taken beq, squashed addi, then a normal add
    set_in(6'd16, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    tick();
    chk("beq_taken", {31'd0, a_branch_taken}, 32'd1);
    chk("beq_target", a_target_pc, 32'h40);
    chk("beq_valid", {31'd0, am_valid}, 32'd1);
    chk("beq_wb", {31'd0, am_is_wb}, 32'd0);
    set_in(6'd0, 32'd1, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    #1;
    chk("flush_ready", {31'd0, a_ready}, 32'd1);
    tick();
    chk("squash_valid", {31'd0, am_valid}, 32'd0);
    chk("squash_taken_pulse", {31'd0, a_branch_taken}, 32'd0);
    set_in(6'd0, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    chk("after_squash_valid", {31'd0, am_valid}, 32'd1);
    chk("after_squash_result", am_alu_result, 32'd8);
    tick();

    // Not-taken bne does not squash
    set_in(6'd17, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
    tick();
    chk("bne_nt_taken", {31'd0, a_branch_taken}, 32'd0);
    set_in(6'd0, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    chk("bne_nt_next_valid", {31'd0, am_valid}, 32'd1);
    chk("bne_nt_next_result", am_alu_result, 32'd4);
    tick();

    // Reset during FLUSH cancels the pending squash
    set_in(6'd16, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
    tick();
    d_ready = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    set_in(6'd0, 32'd6, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    chk("rst_flush_valid", {31'd0, am_valid}, 32'd1);
    chk("rst_flush_result", am_alu_result, 32'd7);
    tick();

`ifdef A_EXECUTE_MUL_EN
    set_in(6'd32, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    chk("mul_busy_ready", {31'd0, a_ready}, 32'd0);
    n = 0;
    while (am_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mul_latency", n, 32'd32);
    chk("mul_result", am_alu_result, 32'hFFFFFFFD);
    tick();
    set_in(6'd32, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b0;
    #1;
    chk("mul_rst_valid", {31'd0, am_valid}, 32'd0);
    chk("mul_rst_result", am_alu_result, 32'd0);
    chk("mul_rst_ready", {31'd0, a_ready}, 32'd1);
    reset = 1'b1;
    tick();
`else
    set_in(6'd32, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick();
    d_ready = 1'b0;
    chk("nomul_valid", {31'd0, am_valid}, 32'd1);
    chk("nomul_result", am_alu_result, 32'd0);
    tick();
`endif

    // Random traffic against the behavioural model
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_valid = 0; m_bt = 0; m_flush = 0; m_mul_left = 0;
    m_res = '0; m_sd = '0; m_tpc = '0; m_prod = '0; m_ws = '0; m_wb = 0; m_ld = 0; m_st = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      da_ALU_Control = codes[$urandom_range(0, 14)];
      da_is_branch = (da_ALU_Control == 6'd16 || da_ALU_Control == 6'd17);
      da_data1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      da_data2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      da_imm32 = $urandom;
      da_use_imm = 1'($urandom_range(0, 1));
      if (da_is_branch && $urandom_range(0, 1) == 1) begin
        da_data2 = da_data1;
        da_use_imm = 1'b0;
      end
      da_is_load = 1'($urandom_range(0, 1));
      da_is_store = 1'($urandom_range(0, 1));
      da_is_wb = 1'($urandom_range(0, 1));
      da_write_sel = 5'($urandom_range(0, 31));
      da_target_PC = $urandom;
      da_pc = $urandom;
      d_ready = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);

      exp_ready = (m_mul_left == 0) && (!m_valid || m_ready);
      @(negedge clock);
      chk("rnd_ready", {31'd0, a_ready}, {31'd0, exp_ready});
      chk("rnd_valid", {31'd0, am_valid}, {31'd0, m_valid});
      chk("rnd_taken", {31'd0, a_branch_taken}, {31'd0, m_bt});
      if (m_bt) chk("rnd_target", a_target_pc, m_tpc);
      if (m_valid) begin
        chk("rnd_result", am_alu_result, m_res);
        chk("rnd_sdata", am_store_data, m_sd);
        chk("rnd_wsel", {27'd0, am_write_sel}, {27'd0, m_ws});
        chk("rnd_flags", {29'd0, am_is_wb, am_is_load, am_is_store}, {29'd0, m_wb, m_ld, m_st});
      end

      @(posedge clock);
      a = da_data1;
      b = da_use_imm ? da_imm32 : da_data2;
      m_bt = 0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_valid = 1;
          m_res = m_prod;
        end
      end else if (d_ready && exp_ready) begin
        if (m_flush) begin
          m_valid = 0;
          m_flush = 0;
        end else begin
          m_sd = da_data2;
          m_ws = da_write_sel;
          m_wb = da_is_wb && !da_is_branch;
          m_ld = da_is_load && !da_is_branch;
          m_st = da_is_store && !da_is_branch;
          if (MulEn && da_ALU_Control == 6'd32) begin
            m_valid = 0;
            m_mul_left = 32;
            m_prod = a * b;
          end else begin
            m_valid = 1;
            m_res = ref_alu(da_ALU_Control, a, b);
            if (da_is_branch && ((da_ALU_Control == 6'd16) == (a == b))) begin
              m_bt = 1;
              m_tpc = da_target_PC;
              m_flush = 1;
            end
          end
        end
      end else if (m_valid && m_ready) begin
        m_valid = 0;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
